// File: rtl/ret_addr_stack.sv
// ----------------------------------------------------------------------------
// Module   : ret_addr_stack
// Brief    : Circular return-address stack for the frontend branch predictor.
//            Optional macro RAS_OVERFLOW_WRAP_EN: a push while full overwrites
//            the oldest entry instead of being dropped.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module ret_addr_stack #(
  parameter int DEPTH = 2,
  parameter int VLEN  = 39
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [VLEN-1:0] data_i,
  output logic            valid_o,
  output logic [VLEN-1:0] addr_o,
  output logic            ovf_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

`ifdef RAS_OVERFLOW_WRAP_EN
  localparam bit c_WRAP_EN = 1'b1;
`else
  localparam bit c_WRAP_EN = 1'b0;
`endif

  logic            r_valid [DEPTH];
  logic [VLEN-1:0] r_addr  [DEPTH];
  logic [PTR_W-1:0] r_tp;
  logic [CNT_W-1:0] r_cnt;

  logic             w_empty;
  logic             w_full;
  logic [PTR_W-1:0] w_tp_inc;
  logic [PTR_W-1:0] w_tp_dec;
  logic             w_push_only;
  logic             w_pop_only;
  logic             w_push_pop;

  assign w_empty     = (r_cnt == '0);
  assign w_full      = (r_cnt == CNT_W'(DEPTH));
  assign w_tp_inc    = r_tp + PTR_W'(1);
  assign w_tp_dec    = r_tp - PTR_W'(1);
  assign w_push_only = push_i && !pop_i;
  assign w_pop_only  = pop_i && !push_i;
  // On an empty stack a simultaneous push & pop degenerates to a plain push.
  assign w_push_pop  = push_i && pop_i && !w_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_addr[i]  <= '0;
      end
      r_tp  <= '0;
      r_cnt <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
      end
      r_tp  <= '0;
      r_cnt <= '0;
    end else if (w_push_pop) begin
      r_valid[r_tp] <= 1'b1;
      r_addr[r_tp]  <= data_i;
    end else if (push_i && (!w_full || c_WRAP_EN)) begin
      r_tp              <= w_tp_inc;
      r_valid[w_tp_inc] <= 1'b1;
      r_addr[w_tp_inc]  <= data_i;
      if (!w_full) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else if (w_pop_only && !w_empty) begin
      r_valid[r_tp] <= 1'b0;
      r_tp          <= w_tp_dec;
      r_cnt         <= r_cnt - CNT_W'(1);
    end
  end

  assign valid_o = !w_empty;
  assign addr_o  = valid_o ? r_addr[r_tp] : '0;
  assign ovf_o   = !flush_i && w_push_only && w_full;

endmodule

`default_nettype wire

// File: tb/tb_ret_addr_stack.sv
// ----------------------------------------------------------------------------
// Module   : tb_ret_addr_stack
// Brief    : Directed self-checking bench for ret_addr_stack (DEPTH=2, VLEN=39).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ret_addr_stack;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        push_i;
  logic        pop_i;
  logic [38:0] data_i;
  logic        valid_o;
  logic [38:0] addr_o;
  logic        ovf_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ret_addr_stack #(.DEPTH(2), .VLEN(39)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push_i),
    .pop_i   (pop_i),
    .data_i  (data_i),
    .valid_o (valid_o),
    .addr_o  (addr_o),
    .ovf_o   (ovf_o)
  );

  task automatic drive(input logic f, input logic p, input logic o, input logic [38:0] d);
    flush_i = f;
    push_i  = p;
    pop_i   = o;
    data_i  = d;
  endtask

  // Inputs are applied 1 time unit after a rising edge; state is read 1 unit after the next.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    drive(0, 0, 0, '0);
    cyc();
    cyc();
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (valid_o !== 1'b0 || addr_o !== 39'h0 || ovf_o !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle[%0d]: got valid=%b addr=%h ovf=%b, want 0/0/0", i, valid_o, addr_o, ovf_o);
      end
      cyc();
    end
  endtask

  task automatic test_push_pop();
    drive(0, 1, 0, 39'h1004); cyc();
    total++;
    if (valid_o !== 1'b1 || addr_o !== 39'h1004) begin
      bad++; $display("FAIL push1: got valid=%b addr=%h, want 1/1004", valid_o, addr_o);
    end
    drive(0, 1, 0, 39'h2008); cyc();
    total++;
    if (valid_o !== 1'b1 || addr_o !== 39'h2008) begin
      bad++; $display("FAIL push2: got valid=%b addr=%h, want 1/2008", valid_o, addr_o);
    end
    drive(0, 0, 1, '0); cyc();
    total++;
    if (valid_o !== 1'b1 || addr_o !== 39'h1004) begin
      bad++; $display("FAIL pop1: got valid=%b addr=%h, want 1/1004", valid_o, addr_o);
    end
    cyc();
    total++;
    if (valid_o !== 1'b0 || addr_o !== 39'h0) begin
      bad++; $display("FAIL pop2_empty: got valid=%b addr=%h, want 0/0", valid_o, addr_o);
    end
    #1;
    total++;
    if (ovf_o !== 1'b0) begin
      bad++; $display("FAIL pop_empty_ovf: got ovf=%b, want 0", ovf_o);
    end
    cyc();
    total++;
    if (valid_o !== 1'b0 || addr_o !== 39'h0) begin
      bad++; $display("FAIL pop3_empty: got valid=%b addr=%h, want 0/0", valid_o, addr_o);
    end
    drive(0, 0, 0, '0);
  endtask

  task automatic test_overflow();
    drive(0, 1, 0, 39'h1004); cyc();
    drive(0, 1, 0, 39'h2008); cyc();
    drive(0, 1, 0, 39'h3000); #1;
    total++;
    if (ovf_o !== 1'b1) begin
      bad++; $display("FAIL ovf_pulse: got ovf=%b, want 1", ovf_o);
    end
    cyc();
    drive(0, 0, 0, '0); #1;
    total++;
    if (ovf_o !== 1'b0) begin
      bad++; $display("FAIL ovf_clear: got ovf=%b, want 0", ovf_o);
    end
`ifdef RAS_OVERFLOW_WRAP_EN
    total++;
    if (valid_o !== 1'b1 || addr_o !== 39'h3000) begin
      bad++; $display("FAIL ovf_top: got valid=%b addr=%h, want 1/3000", valid_o, addr_o);
    end
    drive(0, 0, 1, '0); cyc();
    total++;
    if (valid_o !== 1'b1 || addr_o !== 39'h2008) begin
      bad++; $display("FAIL ovf_pop1: got valid=%b addr=%h, want 1/2008", valid_o, addr_o);
    end
`else
    total++;
    if (valid_o !== 1'b1 || addr_o !== 39'h2008) begin
      bad++; $display("FAIL ovf_top: got valid=%b addr=%h, want 1/2008", valid_o, addr_o);
    end
    drive(0, 0, 1, '0); cyc();
    total++;
    if (valid_o !== 1'b1 || addr_o !== 39'h1004) begin
      bad++; $display("FAIL ovf_pop1: got valid=%b addr=%h, want 1/1004", valid_o, addr_o);
    end
`endif
    cyc();
    total++;
    if (valid_o !== 1'b0 || addr_o !== 39'h0) begin
      bad++; $display("FAIL ovf_pop2: got valid=%b addr=%h, want 0/0", valid_o, addr_o);
    end
    drive(0, 0, 0, '0);
  endtask

  task automatic test_push_and_pop();
    drive(0, 1, 0, 39'h1004); cyc();
    drive(0, 1, 1, 39'h4000); #1;
    total++;
    if (ovf_o !== 1'b0) begin
      bad++; $display("FAIL pp_ovf: got ovf=%b, want 0", ovf_o);
    end
    cyc();
    total++;
    if (valid_o !== 1'b1 || addr_o !== 39'h4000) begin
      bad++; $display("FAIL pp_replace: got valid=%b addr=%h, want 1/4000", valid_o, addr_o);
    end
    drive(0, 0, 1, '0); cyc();
    total++;
    if (valid_o !== 1'b0 || addr_o !== 39'h0) begin
      bad++; $display("FAIL pp_pop: got valid=%b addr=%h, want 0/0", valid_o, addr_o);
    end
    drive(0, 1, 1, 39'h5000); cyc();
    total++;
    if (valid_o !== 1'b1 || addr_o !== 39'h5000) begin
      bad++; $display("FAIL pp_empty: got valid=%b addr=%h, want 1/5000", valid_o, addr_o);
    end
    drive(0, 0, 1, '0); cyc();
    total++;
    if (valid_o !== 1'b0) begin
      bad++; $display("FAIL pp_empty_pop: got valid=%b, want 0", valid_o);
    end
    drive(0, 0, 0, '0);
  endtask

  task automatic test_flush();
    drive(0, 1, 0, 39'h1004); cyc();
    drive(0, 1, 0, 39'h2008); cyc();
    drive(1, 1, 0, 39'h6000); #1;
    total++;
    if (ovf_o !== 1'b0) begin
      bad++; $display("FAIL flush_ovf: got ovf=%b, want 0", ovf_o);
    end
    cyc();
    total++;
    if (valid_o !== 1'b0 || addr_o !== 39'h0) begin
      bad++; $display("FAIL flush_clear: got valid=%b addr=%h, want 0/0", valid_o, addr_o);
    end
    drive(0, 1, 0, 39'h7000); cyc();
    total++;
    if (valid_o !== 1'b1 || addr_o !== 39'h7000) begin
      bad++; $display("FAIL flush_push: got valid=%b addr=%h, want 1/7000", valid_o, addr_o);
    end
    drive(0, 0, 1, '0); cyc();
    drive(0, 0, 0, '0);
  endtask

  task automatic test_async_reset();
    drive(0, 1, 0, 39'h1004); cyc();
    drive(0, 1, 0, 39'h2008); cyc();
    drive(0, 0, 0, '0);
    #2;
    rst_ni = 1'b0;
    #1;
    total++;
    if (valid_o !== 1'b0 || addr_o !== 39'h0) begin
      bad++; $display("FAIL async_reset: got valid=%b addr=%h, want 0/0", valid_o, addr_o);
    end
    cyc();
    rst_ni = 1'b1;
    drive(0, 1, 0, 39'h8000); cyc();
    total++;
    if (valid_o !== 1'b1 || addr_o !== 39'h8000) begin
      bad++; $display("FAIL post_reset_push: got valid=%b addr=%h, want 1/8000", valid_o, addr_o);
    end
    drive(0, 0, 0, '0);
  endtask

  initial begin
    drive(0, 0, 0, '0);
    rst_ni = 1'b0;
    #1;
    test_reset();
    test_push_pop();
    test_overflow();
    test_push_and_pop();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
